hazard_stall_controller: RTL
============================

// Module: hazard_stall_controller
// PURPOSE
//  Pipeline interlock sequencer for the ID stage, where branches, jumps and JR resolve.
//  Detects load-use and branch-operand hazards against ID/EX and EX/MEM.
//  Tracks occupancy of the multi-cycle HI/LO multiplier with a busy counter.
//  Drives PC/IF_ID write enables, the ID/EX bubble and the IF/ID flush on a taken branch.
// PARAMETERS
//  MUL_LATENCY  4  cycles the multiplier is busy after issue (1..15)
// PORTS
//  Clk                   in   1  rising-edge clock
//  Rst                   in   1  synchronous reset, active-high
//  IF_ID_rs              in   5  rs field of the instruction in ID
//  IF_ID_rt              in   5  rt field of the instruction in ID
//  ID_UsesRs             in   1  ID instruction reads rs
//  ID_UsesRt             in   1  ID instruction reads rt
//  ID_Branch             in   1  ID instruction compares or reads operands in ID (beq/bne/bgez/jr...)
//  ID_PCSrc              in   1  branch/jump taken, from the ID stage
//  ID_MulStart           in   1  ID instruction issues mult/madd/msub
//  ID_MulUse             in   1  ID instruction reads HI/LO (mfhi/mflo)
//  ID_EX_RegWrite        in   1  EX-stage instruction writes a register
//  ID_EX_MemRead         in   1  EX-stage instruction is a load
//  ID_EX_WriteRegister   in   5  EX-stage destination register
//  EX_MEM_MemRead        in   1  MEM-stage instruction is a load
//  EX_MEM_WriteRegister  in   5  MEM-stage destination register
//  PC_Write              out  1  PC load enable
//  IF_ID_Write           out  1  IF/ID load enable
//  ID_EX_Bubble          out  1  zero the control fields written into ID/EX
//  IF_ID_Flush           out  1  clear IF/ID (squash the fetched instruction)
//  Mul_Busy              out  1  multiplier counter nonzero
//  Stall_Reason          out  2  00 none, 01 load-use, 10 branch operand, 11 multiplier busy
// BEHAVIOUR
//  - Register match: Uses* asserted and the register is equal and nonzero. Register 0 never matches.
//  - Hazards are combinational on the current inputs. Priority when several apply:
//    - LU: ID_EX_MemRead and a match against ID_EX_WriteRegister.
//    - BR: ID_Branch and one of
//      - ID_EX_RegWrite and a match against ID_EX_WriteRegister, or
//      - EX_MEM_MemRead and a match against EX_MEM_WriteRegister.
//    - MB: mul_cnt != 0 and (ID_MulUse or ID_MulStart).
//  - stall = LU|BR|MB. While stall: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0.
//    Otherwise PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0.
//  - A load feeding a branch stalls 2 cycles: LU first, then BR via EX_MEM.
//    An ALU result feeding a branch stalls 1 cycle.
//  - IF_ID_Flush = ID_PCSrc & ~stall. ID_PCSrc is ignored while stalled because operands are stale.
//  - mul_cnt[3:0] state machine:
//    - IDLE (cnt=0): on ID_MulStart & ~stall, load MUL_LATENCY and go to BUSY.
//    - BUSY: decrement every cycle, including stalled cycles; at 1 -> 0 go to IDLE.
//      ID_MulStart in BUSY stalls (structural hazard); the counter is not reloaded.
//    - A start is accepted the same cycle the counter reaches 0 (cnt==0 is evaluated pre-edge).
//  - Mul_Busy = (mul_cnt != 0), registered.
//  - Reset (sync): mul_cnt=0, state IDLE, Stall_Reason=00.
//    Outputs held at PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0, Mul_Busy=0.
//    Reset mid-multiply abandons it; the next cycle is IDLE.
//  - Latency: hazard outputs are zero-cycle (combinational); Mul_Busy is 1 cycle after issue.
// CONFIGURATION
//  - HAZ_STALL_COUNT_EN defined: adds output Stall_Count[31:0].
//    - Increments on every cycle with stall=1 and Rst=0; saturates at 32'hFFFFFFFF.
//    - Cleared by Rst.
//  - Not defined: the port is absent; no counter logic.
// TESTING
//  - lw $t0 in EX (ID_EX_MemRead=1, ID_EX_WriteRegister=8); ID add reads rs=8
//    -> 1 cycle of PC_Write=0, Bubble=1, Reason=01; the next cycle is clear.
//  - lw $t0 in EX; ID beq rs=8 -> cycle 1 Reason=01; cycle 2 (EX_MEM_MemRead=1, reg 8) Reason=10; cycle 3 no stall.
//  - ID_EX_WriteRegister=0 with RegWrite=1; ID reads rs=0 -> no stall.
//    ID_PCSrc=1 -> IF_ID_Flush=1 for exactly 1 cycle.
//  - ID_MulStart at t0 with MUL_LATENCY=4; mfhi in ID at t1
//    -> stalled t1..t4 with Reason=11; proceeds at t5; Mul_Busy high t1..t4.
//  - Branch taken (ID_PCSrc=1) during a BR stall -> no flush until the stall clears.
//    Rst at t2 of a multiply -> Mul_Busy=0 at t3, mfhi not stalled.
//  - HAZ_STALL_COUNT_EN: 3 LU stalls plus 4 MB stalls -> Stall_Count=7; Rst -> 0.

Source files
------------

// File: rtl/hazard_stall_controller_if.sv
// ID-stage hazard interface: pipeline register fields in, interlock controls out.
// The master drives the pipeline view; the slave is the interlock controller.
interface hazard_stall_controller_if;
    logic [4:0] IF_ID_rs;
    logic [4:0] IF_ID_rt;
    logic       ID_UsesRs;
    logic       ID_UsesRt;
    logic       ID_Branch;
    logic       ID_PCSrc;
    logic       ID_MulStart;
    logic       ID_MulUse;
    logic       ID_EX_RegWrite;
    logic       ID_EX_MemRead;
    logic [4:0] ID_EX_WriteRegister;
    logic       EX_MEM_MemRead;
    logic [4:0] EX_MEM_WriteRegister;
    logic       PC_Write;
    logic       IF_ID_Write;
    logic       ID_EX_Bubble;
    logic       IF_ID_Flush;
    logic       Mul_Busy;
    logic [1:0] Stall_Reason;

    modport master (
        output IF_ID_rs, IF_ID_rt, ID_UsesRs, ID_UsesRt, ID_Branch, ID_PCSrc,
               ID_MulStart, ID_MulUse, ID_EX_RegWrite, ID_EX_MemRead,
               ID_EX_WriteRegister, EX_MEM_MemRead, EX_MEM_WriteRegister,
        input  PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Mul_Busy, Stall_Reason
    );

    modport slave (
        input  IF_ID_rs, IF_ID_rt, ID_UsesRs, ID_UsesRt, ID_Branch, ID_PCSrc,
               ID_MulStart, ID_MulUse, ID_EX_RegWrite, ID_EX_MemRead,
               ID_EX_WriteRegister, EX_MEM_MemRead, EX_MEM_WriteRegister,
        output PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Mul_Busy, Stall_Reason
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// ID-stage interlock: load-use, branch-operand and multiplier-busy stalls plus taken-branch flush.
// Optional macro HAZ_STALL_COUNT_EN adds a saturating 32-bit stalled-cycle counter output.
module hazard_stall_controller #(
    parameter int MUL_LATENCY = 4
) (
    input  logic Clk,
    input  logic Rst,
    hazard_stall_controller_if.slave hz
`ifdef HAZ_STALL_COUNT_EN
    ,
    output logic [31:0] Stall_Count
`endif
);
    typedef enum logic {IDLE, BUSY} mul_state_t;

    mul_state_t state, state_nxt;
    logic [3:0] mul_cnt, cnt_nxt;
    logic       mul_busy;
    logic       ex_rs, ex_rt, mem_rs, mem_rt;
    logic       lu, br, mb, stall;
    logic [1:0] reason;

    // Register 0 is hardwired, so it can never carry a hazard.
    function automatic logic reg_match(input logic uses, input logic [4:0] src, input logic [4:0] dst);
        return uses && (src == dst) && (src != 5'd0);
    endfunction

    assign ex_rs  = reg_match(hz.ID_UsesRs, hz.IF_ID_rs, hz.ID_EX_WriteRegister);
    assign ex_rt  = reg_match(hz.ID_UsesRt, hz.IF_ID_rt, hz.ID_EX_WriteRegister);
    assign mem_rs = reg_match(hz.ID_UsesRs, hz.IF_ID_rs, hz.EX_MEM_WriteRegister);
    assign mem_rt = reg_match(hz.ID_UsesRt, hz.IF_ID_rt, hz.EX_MEM_WriteRegister);

    assign lu = hz.ID_EX_MemRead && (ex_rs || ex_rt);
    assign br = hz.ID_Branch && ((hz.ID_EX_RegWrite && (ex_rs || ex_rt)) ||
                                 (hz.EX_MEM_MemRead && (mem_rs || mem_rt)));
    assign mb = (mul_cnt != 4'd0) && (hz.ID_MulUse || hz.ID_MulStart);

    always_comb begin
        reason = 2'b00;
        if (Rst)     reason = 2'b00;
        else if (lu) reason = 2'b01;
        else if (br) reason = 2'b10;
        else if (mb) reason = 2'b11;
    end

    assign stall           = (reason != 2'b00);
    assign hz.Stall_Reason = reason;
    assign hz.PC_Write     = ~stall;
    assign hz.IF_ID_Write  = ~stall;
    assign hz.ID_EX_Bubble = stall;
    // Branch decisions made on stale operands are discarded until the stall clears.
    assign hz.IF_ID_Flush  = hz.ID_PCSrc && !stall && !Rst;
    assign hz.Mul_Busy     = mul_busy;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = mul_cnt;
        case (state)
            IDLE: begin
                if (hz.ID_MulStart && !stall) begin
                    cnt_nxt   = 4'(MUL_LATENCY);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // Counts down through stalled cycles too; a new start is refused, not reloaded.
                cnt_nxt = mul_cnt - 4'd1;
                if (mul_cnt == 4'd1) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            mul_cnt  <= 4'd0;
            mul_busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            mul_cnt  <= cnt_nxt;
            mul_busy <= (cnt_nxt != 4'd0);
        end
    end

`ifdef HAZ_STALL_COUNT_EN
    always_ff @(posedge Clk) begin
        if (Rst)
            Stall_Count <= 32'd0;
        else if (stall && (Stall_Count != 32'hFFFF_FFFF))
            Stall_Count <= Stall_Count + 32'd1;
    end
`endif
endmodule
